// File: rtl/vec_alu_seq.sv
// Multi-lane unsigned vector ALU with a handshake front end and an iterative restoring divider.
// Optional define VEC_ALU_SAT_EN makes ADD/MUL clamp high and SUB clamp low instead of wrapping.
module vec_alu_seq #(
  parameter int WIDTH = 20,
  parameter int LANES = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES-1:0][WIDTH-1:0]   A,
  input  logic [LANES-1:0][WIDTH-1:0]   B,
  input  logic [2:0]                    Operation,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES-1:0][WIDTH-1:0]   Result,
  output logic [LANES-1:0]              ovf,
  output logic [LANES-1:0]              dz,
  output logic                          ill
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MOV = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;

  localparam int              CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV_RUN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [LANES-1:0][WIDTH-1:0] result_q;
  logic [LANES-1:0]            ovf_q;
  logic [LANES-1:0]            dz_q;
  logic                        ill_q;

  // Divider working set: quotient shifts in from the dividend, remainder shifts alongside.
  logic [LANES-1:0][WIDTH-1:0] quo_q;
  logic [LANES-1:0][WIDTH-1:0] rem_q;
  logic [LANES-1:0][WIDTH-1:0] b_q;
  logic [CW-1:0]               cnt_q;

  logic [LANES-1:0][WIDTH-1:0] alu_res;
  logic [LANES-1:0]            alu_ovf;
  logic [LANES-1:0][WIDTH-1:0] quo_step;
  logic [LANES-1:0][WIDTH-1:0] rem_step;
  logic [LANES-1:0]            b_zero;
  logic                        accept;
  logic                        is_ill;

  assign accept = in_valid && in_ready;
  assign is_ill = (Operation > OP_DIV);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH:0]         sum;
    logic [WIDTH-1:0]       diff;
    logic                   borrow;
    logic [2*WIDTH-1:0]     prod;
    logic                   prod_ovf;
    logic [WIDTH-1:0]       add_res;
    logic [WIDTH-1:0]       sub_res;
    logic [WIDTH-1:0]       mul_res;
    logic [WIDTH-1:0]       lane_res;
    logic                   lane_ovf;
    logic [WIDTH:0]         shifted;
    logic [WIDTH-1:0]       trial;
    logic                   fits;

    assign sum      = {1'b0, A[i]} + {1'b0, B[i]};
    assign diff     = A[i] - B[i];
    assign borrow   = (A[i] < B[i]);
    assign prod     = {{WIDTH{1'b0}}, A[i]} * {{WIDTH{1'b0}}, B[i]};
    assign prod_ovf = |prod[2*WIDTH-1:WIDTH];

`ifdef VEC_ALU_SAT_EN
    assign add_res = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    assign sub_res = borrow     ? {WIDTH{1'b0}} : diff;
    assign mul_res = prod_ovf   ? {WIDTH{1'b1}} : prod[WIDTH-1:0];
`else
    assign add_res = sum[WIDTH-1:0];
    assign sub_res = diff;
    assign mul_res = prod[WIDTH-1:0];
`endif

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
      lane_res = '0;
      lane_ovf = 1'b0;
      case (Operation)
        OP_ADD: begin lane_res = add_res; lane_ovf = sum[WIDTH]; end
        OP_SUB: begin lane_res = sub_res; lane_ovf = borrow;     end
        OP_MOV: lane_res = A[i];
        OP_MUL: begin lane_res = mul_res; lane_ovf = prod_ovf;   end
        default: ;
      endcase
    end

    assign alu_res[i] = lane_res;
    assign alu_ovf[i] = lane_ovf;

    // A zero divisor always "fits", so the quotient naturally fills with ones.
    assign shifted     = {rem_q[i], quo_q[i][WIDTH-1]};
    assign fits        = (shifted >= {1'b0, b_q[i]});
    assign trial       = shifted[WIDTH-1:0] - b_q[i];
    assign rem_step[i] = fits ? trial : shifted[WIDTH-1:0];
    assign quo_step[i] = {quo_q[i][WIDTH-2:0], fits};
    assign b_zero[i]   = (b_q[i] == '0);
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = (Operation == OP_DIV) ? S_DIV_RUN : S_DONE;
      end
      S_DIV_RUN: begin
        if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
      ovf_q    <= '0;
      dz_q     <= '0;
      ill_q    <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            quo_q <= A;
            b_q   <= B;
            rem_q <= '0;
            cnt_q <= '0;
            if (Operation != OP_DIV) begin
              result_q <= is_ill ? '0 : alu_res;
              ovf_q    <= is_ill ? '0 : alu_ovf;
              dz_q     <= '0;
              ill_q    <= is_ill;
            end
          end
        end
        S_DIV_RUN: begin
          // WIDTH step cycles resolve the quotient; one more cycle commits it.
          if (cnt_q == CNT_LAST) begin
            result_q <= quo_q;
            ovf_q    <= '0;
            dz_q     <= b_zero;
            ill_q    <= 1'b0;
          end else begin
            quo_q <= quo_step;
            rem_q <= rem_step;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Result = result_q;
  assign ovf    = ovf_q;
  assign dz     = dz_q;
  assign ill    = ill_q;

endmodule
